// File: rtl/serial_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per cycle, LSB chunk first.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_adder: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [31:0]      base;
  logic             last_chunk;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             carry_chunk, carry_msb;
  logic             b_inv, c_eff;
  logic [WIDTH-1:0] b_eff;

  // Subtraction is a + ~b + ~c_in, so only the operand and carry get inverted.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_inv = sub;
  assign c_eff = c_in ^ sub;
`else
  assign b_inv = 1'b0;
  assign c_eff = c_in;
`endif
  assign b_eff = b ^ {WIDTH{b_inv}};

  assign base       = 32'(cnt) * 32'(CHUNK);
  assign last_chunk = (cnt == CW'(NCHUNK - 1));
  assign in_ready   = rst_n && (state == IDLE);
  assign out_valid  = (state == DONE);

  // Carry into the chunk MSB is recovered from the sum bit, so CHUNK=1 needs no special case.
  always_comb begin
    a_chunk   = a_reg[base +: CHUNK];
    b_chunk   = b_reg[base +: CHUNK];
    {carry_chunk, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    carry_msb = sum_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= c_eff;
            cnt   <= '0;
          end
        end
        BUSY: begin
          s[base +: CHUNK] <= sum_chunk;
          carry            <= carry_chunk;
          cnt              <= cnt + CW'(1);
          if (last_chunk) begin
            c_out    <= carry_chunk;
            overflow <= carry_msb ^ carry_chunk;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
